// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   state_t     - scanner FSM states
//   KEYMAP      - hex code per (row, col), packed as 16 nibbles, index = row*4 + col
//   key_lookup  - returns the hex code for a given row/column pair
//   lowest_low  - index of the lowest-numbered low bit in an active-low row vector
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Nibble n holds the key at row n/4, column n%4.
    // row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: 0 F E D
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEYMAP[base +: 4];
    endfunction

    // Scan from the top so the lowest low index is the one left standing.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, resets to all ones
// (the idle level of pulled-up, active-low lines).
//   clk   - destination clock
//   reset - synchronous, active-high reset
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            q      <= '1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and reports accepted keys.
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - column drive, active-low, exactly one bit low
//   key_code  - hex value of the last accepted key
//   key_valid - one-cycle strobe when a press is accepted
//   key_held  - high from press acceptance until release acceptance
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 48000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_TICKS) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

    logic [3:0] rs;

    sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (rs)
    );

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    state_t            state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
    logic [3:0]        col_n_q, col_n_d;
    logic              row_active;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;

    // The latched row is still pulled low by the key under test.
    assign row_active = ~rs[row_idx_q];

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        db_cnt_d    = db_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        // Decisions only on tick, so each column gets a full tick to settle.
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&rs) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = lowest_low(rs);
                        db_cnt_d  = '0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_active) begin
                        if (db_cnt_q == DB_LAST) begin
                            key_code_d  = key_lookup(row_idx_q, col_idx_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = HELD;
                        end else begin
                            db_cnt_d = db_cnt_q + DB_ONE;
                        end
                    end else begin
                        // Bounce: give up on this column and move on.
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    // Column stays frozen; other rows are ignored here.
                    if (!row_active) begin
                        db_cnt_d = '0;
                        state_d  = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_active) begin
                        if (db_cnt_q == DB_LAST) begin
                            key_held_d = 1'b0;
                            col_idx_d  = col_idx_q + 2'd1;
                            state_d    = SCAN;
                        end else begin
                            db_cnt_d = db_cnt_q + DB_ONE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end

        col_n_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            db_cnt_q    <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            col_n_q     <= 4'b1110;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            db_cnt_q    <= db_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            col_n_q     <= col_n_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad stimulus checked every cycle against a
// behavioural model of the scanner.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Keys currently pressed, bit index = row*4 + col.
    logic [15:0] keys;

    // Keypad as a physical matrix: a pressed key shorts its row to a driven column.
    function automatic logic [3:0] rows_from(input logic [3:0] cols, input logic [15:0] k);
        logic [3:0] r_n;
        r_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (k[r*4+c] && cols[c] === 1'b0) r_n[r] = 1'b0;
            end
        end
        return r_n;
    endfunction

    // ---------------- reference model ----------------
    string      keys_txt = "123A456B789C0FED";
    logic [3:0] pipe [2];     // synchronizer delay line, pipe[1] is the usable sample
    int         m_div;
    int         m_col;
    int         m_phase;      // 0 scanning, 1 confirming press, 2 held, 3 confirming release
    int         m_row;
    int         m_conf;       // consecutive confirming ticks seen
    logic [3:0] m_code;
    bit         m_held;
    bit         m_valid;

    function automatic logic [3:0] hexval(input byte ch);
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        return 4'(ch - "A" + 10);
    endfunction

    task automatic model_step(input logic [3:0] rin, input bit rst);
        logic [3:0] rs;
        bit         on_tick;
        bit         down;
        if (rst) begin
            pipe[0] = 4'hF; pipe[1] = 4'hF;
            m_div = 0; m_col = 0; m_phase = 0; m_row = 0; m_conf = 0;
            m_code = 4'h0; m_held = 0; m_valid = 0;
            return;
        end
        rs      = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = rin;
        m_valid = 0;
        on_tick = (m_div == SCAN_DIV - 1);
        m_div   = (m_div + 1) % SCAN_DIV;
        if (!on_tick) return;
        down = (rs[m_row] == 1'b0);
        case (m_phase)
            0: begin
                if (rs == 4'hF) begin
                    m_col = (m_col + 1) % 4;
                end else begin
                    m_row = 3;
                    for (int i = 3; i >= 0; i--) if (rs[i] == 1'b0) m_row = i;
                    m_conf  = 0;
                    m_phase = 1;
                end
            end
            1: begin
                if (down) begin
                    m_conf++;
                    if (m_conf == DEBOUNCE_TICKS) begin
                        m_code  = hexval(keys_txt[m_row*4 + m_col]);
                        m_valid = 1;
                        m_held  = 1;
                        m_phase = 2;
                    end
                end else begin
                    m_col   = (m_col + 1) % 4;
                    m_phase = 0;
                end
            end
            2: begin
                if (!down) begin
                    m_conf  = 0;
                    m_phase = 3;
                end
            end
            default: begin
                if (!down) begin
                    m_conf++;
                    if (m_conf == DEBOUNCE_TICKS) begin
                        m_held  = 0;
                        m_col   = (m_col + 1) % 4;
                        m_phase = 0;
                    end
                end else begin
                    m_phase = 2;
                end
            end
        endcase
    endtask

    // One clock: drive inputs, advance DUT and model together, compare outputs.
    task automatic run_cycles(input int n);
        logic [3:0] rin;
        bit         rst;
        logic [3:0] exp_col;
        for (int i = 0; i < n; i++) begin
            rin   = rows_from(col_n, keys);
            rst   = reset;
            row_n = rin;
            @(posedge clk);
            model_step(rin, rst);
            #1;
            exp_col = ~(4'b0001 << m_col);
            check("col_n", 32'(col_n), 32'(exp_col));
            check("key_code", 32'(key_code), 32'(m_code));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_held", 32'(key_held), 32'(m_held));
        end
    endtask

    int m_strobes = 0;
    always @(posedge clk) if (m_valid) m_strobes <= m_strobes + 1;

    initial begin
        keys  = '0;
        row_n = 4'hF;
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;

        // Idle scan.
        run_cycles(40);

        // Key '5' (row1, col1), then release.
        keys = 16'(1 << 5);
        run_cycles(60);
        keys = '0;
        run_cycles(40);

        // Hold '5', add '9', release '5', then release '9'.
        keys = 16'(1 << 5);
        run_cycles(50);
        keys = keys | 16'(1 << 10);
        run_cycles(30);
        keys = 16'(1 << 10);
        run_cycles(80);
        keys = '0;
        run_cycles(40);

        // Rows 0 and 3 on column 0: lowest row wins.
        keys = 16'(1 << 0) | 16'(1 << 12);
        run_cycles(60);
        keys = '0;
        run_cycles(40);

        // Reset while held, key still pressed afterwards.
        keys = 16'(1 << 5);
        run_cycles(50);
        reset = 1'b1;
        run_cycles(1);
        reset = 1'b0;
        run_cycles(80);
        keys = '0;
        run_cycles(40);

        // Random episodes, short durations produce bounces.
        for (int e = 0; e < 150; e++) begin
            keys = 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) keys = keys | 16'(1 << $urandom_range(0, 15));
            run_cycles($urandom_range(1, 45));
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                run_cycles(1);
                reset = 1'b0;
            end
            keys = '0;
            run_cycles($urandom_range(1, 40));
        end
        run_cycles(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
